// File: rtl/burst_reverser.sv
// burst_reverser: captures a burst of WIDTH-bit words into a register array
// and replays it to a busy-flagged sink once the burst ends.
// Playback is last-in-first-out. Defining BURST_REV_FIFO_EN honours the
// mode input, which is latched at drain start (1 = in-order playback).
module burst_reverser #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     i_valid,
   input  logic [WIDTH-1:0]         Din,
   input  logic                     busy,
   input  logic                     mode,
   output logic [WIDTH-1:0]         Dout,
   output logic                     o_valid,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
   localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

   typedef enum logic {LOAD, DRAIN} state_t;

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  mem [DEPTH];
   logic [AW:0]       count_q, count_d;
   logic              full_q;
   logic              ovf_q;
   logic [WIDTH-1:0]  dout_p1;
   logic              vld_p1;

   logic              wr_en;
   logic              emit;
   logic              start;
   logic              drop;
   logic              clr_ovf;
   logic [AW-1:0]     rd_addr;

   // State register; reset lands in LOAD.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= LOAD;
      else        state_q <= state_d;
   end

   // Next-state and per-cycle control decode.
   always_comb begin
      state_d = state_q;
      wr_en   = 1'b0;
      emit    = 1'b0;
      start   = 1'b0;
      drop    = 1'b0;
      clr_ovf = 1'b0;
      case (state_q)
         LOAD: begin
            if (i_valid) begin
               if (!full_q) begin
                  wr_en   = 1'b1;
                  clr_ovf = (count_q == '0);
               end else begin
                  drop = 1'b1;
               end
            end else if (count_q != '0 && !busy) begin
               // First word leaves on the same edge as the state change; a
               // one-word burst is finished immediately and stays in LOAD.
               start = 1'b1;
               emit  = 1'b1;
               if (count_q != CNT_ONE) state_d = DRAIN;
            end
         end
         DRAIN: begin
            drop = i_valid;
            if (!busy) begin
               emit = 1'b1;
               if (count_q == CNT_ONE) state_d = LOAD;
            end
         end
         default: state_d = LOAD;
      endcase
   end

   // Occupancy after this edge: writes and emits never coincide.
   always_comb begin
      count_d = count_q;
      if (wr_en)     count_d = count_q + CNT_ONE;
      else if (emit) count_d = count_q - CNT_ONE;
   end

`ifdef BURST_REV_FIFO_EN
   logic          mode_q;
   logic          fifo_sel;
   logic [AW-1:0] rd_ptr_q;

   // The live mode input only matters on the start edge; afterwards the latched copy rules.
   assign fifo_sel = start ? mode : mode_q;

   // Read address: in-order pointer for FIFO, top of stack for LIFO.
   always_comb begin
      if (fifo_sel) rd_addr = start ? '0 : rd_ptr_q;
      else          rd_addr = AW'(count_q - CNT_ONE);
   end

   // Latch playback mode at drain start and advance the in-order pointer per emit.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mode_q   <= 1'b0;
         rd_ptr_q <= '0;
      end else begin
         if (start) mode_q   <= mode;
         if (emit)  rd_ptr_q <= rd_addr + AW'(1);
      end
   end
`else
   logic unused_mode;
   assign unused_mode = mode;
   // LIFO only: the top of stack is always entry count-1.
   assign rd_addr = AW'(count_q - CNT_ONE);
`endif

   // Storage array; contents are don't-care after reset.
   always_ff @(posedge clk) begin
      if (wr_en) mem[count_q[AW-1:0]] <= Din;
   end

   // ---- stage p1: registered occupancy, flags and output word ----
   // Registered status and output word; Dout is forced to zero when not valid.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
         full_q  <= 1'b0;
         ovf_q   <= 1'b0;
         vld_p1  <= 1'b0;
         dout_p1 <= '0;
      end else begin
         count_q <= count_d;
         full_q  <= (count_d == CNT_FULL);
         vld_p1  <= emit;
         dout_p1 <= emit ? mem[rd_addr] : '0;
         if (drop)         ovf_q <= 1'b1;
         else if (clr_ovf) ovf_q <= 1'b0;
      end
   end

   assign Dout     = dout_p1;
   assign o_valid  = vld_p1;
   assign count    = count_q;
   assign full     = full_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_burst_reverser.sv
// Self-checking bench for burst_reverser (WIDTH=8, DEPTH=16): directed
// scenarios followed by randomized bursts, compared cycle by cycle against a
// queue-based reference model of the buffer behaviour.
module tb_burst_reverser;

   localparam int WIDTH = 8;
   localparam int DEPTH = 16;

   logic             clk = 1'b0;
   logic             reset;
   logic             i_valid;
   logic [WIDTH-1:0] Din;
   logic             busy;
   logic             mode;
   logic [WIDTH-1:0] Dout;
   logic             o_valid;
   logic [4:0]       count;
   logic             full;
   logic             overflow;

   int errors = 0;
   int checks = 0;

   // reference model state
   logic [WIDTH-1:0] held[$];
   logic [WIDTH-1:0] play[$];
   bit               draining = 0;
   bit               m_ovf = 0;
   logic [WIDTH-1:0] e_dout = '0;
   bit               e_vld = 0;

   burst_reverser #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .i_valid(i_valid), .Din(Din), .busy(busy),
      .mode(mode), .Dout(Dout), .o_valid(o_valid), .count(count),
      .full(full), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int exp_count();
      return draining ? play.size() : held.size();
   endfunction

   task automatic pop_emit();
      e_dout = play.pop_front();
      e_vld  = 1;
      if (play.size() == 0) draining = 0;
   endtask

   // One clock edge of the buffer as described behaviourally.
   task automatic model(input bit iv, input logic [WIDTH-1:0] d, input bit b, input bit md);
      bit fifo;
      e_vld  = 0;
      e_dout = '0;
      if (!draining) begin
         if (iv) begin
            if (held.size() < DEPTH) begin
               if (held.size() == 0) m_ovf = 0;
               held.push_back(d);
            end else begin
               m_ovf = 1;
            end
         end else if (held.size() != 0 && !b) begin
`ifdef BURST_REV_FIFO_EN
            fifo = md;
`else
            fifo = 0;
`endif
            play.delete();
            if (fifo) foreach (held[i]) play.push_back(held[i]);
            else for (int i = held.size() - 1; i >= 0; i--) play.push_back(held[i]);
            held.delete();
            draining = 1;
            pop_emit();
         end
      end else begin
         if (iv) m_ovf = 1;
         if (!b) pop_emit();
      end
   endtask

   task automatic compare_all(input string tag);
      check({tag, ".o_valid"},  32'(o_valid),  32'(e_vld));
      check({tag, ".Dout"},     32'(Dout),     32'(e_dout));
      check({tag, ".count"},    32'(count),    32'(exp_count()));
      check({tag, ".full"},     32'(full),     32'(exp_count() == DEPTH));
      check({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
   endtask

   task automatic step(input string tag, input bit iv, input logic [WIDTH-1:0] d,
                       input bit b, input bit md);
      i_valid = iv; Din = d; busy = b; mode = md;
      @(posedge clk);
      model(iv, d, b, md);
      #1;
      compare_all(tag);
   endtask

   task automatic model_reset();
      held.delete(); play.delete();
      draining = 0; m_ovf = 0; e_vld = 0; e_dout = '0;
   endtask

   // Assert reset between edges, check outputs before any edge, then release.
   task automatic async_reset(input string tag);
      i_valid = 0; busy = 0; mode = 0; Din = '0;
      #2 reset = 1'b0;
      #1;
      model_reset();
      compare_all(tag);
      repeat (2) @(posedge clk);
      @(negedge clk) reset = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_n(input string tag, input int n, input bit md);
      for (int i = 0; i < n; i++) step(tag, 0, '0, 0, md);
   endtask

   initial begin
      int n;
      bit md;
      reset = 1'b0; i_valid = 0; Din = '0; busy = 0; mode = 0;
      #3;
      model_reset();
      compare_all("reset");
      @(negedge clk) reset = 1'b1;
      @(posedge clk);
      #1;

      // LIFO basic
      step("lifo_wr", 1, 8'h11, 0, 0);
      step("lifo_wr", 1, 8'h22, 0, 0);
      step("lifo_wr", 1, 8'h33, 0, 0);
      idle_n("lifo_rd", 4, 0);

      // mode=1 playback
      step("fifo_wr", 1, 8'h11, 0, 1);
      step("fifo_wr", 1, 8'h22, 0, 1);
      step("fifo_wr", 1, 8'h33, 0, 1);
      idle_n("fifo_rd", 4, 1);

      // Backpressure after first output
      for (int i = 0; i < 4; i++) step("bp_wr", 1, 8'hA0 + 8'(i), 0, 0);
      step("bp_rd", 0, '0, 0, 0);
      step("bp_busy", 0, '0, 1, 0);
      step("bp_busy", 0, '0, 1, 0);
      idle_n("bp_rd", 4, 0);

      // Full and overflow
      for (int i = 0; i <= 16; i++) step("full_wr", 1, 8'(i), 0, 0);
      idle_n("full_rd", 17, 0);
      step("ovf_clr", 1, 8'h5A, 0, 0);
      idle_n("ovf_rd", 2, 0);

      // Reset mid-drain
      for (int i = 0; i < 5; i++) step("rst_wr", 1, 8'hC0 + 8'(i), 0, 0);
      idle_n("rst_rd", 2, 0);
      async_reset("rst_mid");
      step("rst_wr2", 1, 8'h77, 0, 0);
      step("rst_wr2", 1, 8'h88, 0, 0);
      idle_n("rst_rd2", 3, 0);

      // Busy held at burst end
      for (int i = 0; i < 3; i++) step("bend_wr", 1, 8'h40 + 8'(i), 0, 0);
      for (int i = 0; i < 4; i++) step("bend_busy", 0, '0, 1, 0);
      idle_n("bend_rd", 4, 0);

      // Randomized bursts
      for (int k = 0; k < 60; k++) begin
         n  = $urandom_range(0, 19);
         md = 1'($urandom_range(0, 1));
         for (int i = 0; i < n; i++)
            step("rnd_wr", 1, 8'($urandom), ($urandom_range(0, 3) == 0), md);
         for (int c = 0; c < 80 && (draining || held.size() != 0); c++)
            step("rnd_rd", ($urandom_range(0, 19) == 0), 8'($urandom),
                 ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)));
         idle_n("rnd_idle", $urandom_range(0, 2), md);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/burst_reverser.md
# burst_reverser

Parametrised burst buffer that captures a burst of `WIDTH`-bit words from an upstream producer and replays it to a downstream consumer once the burst ends and the consumer is not busy. Replay is last-in-first-out by default; a compile-time option adds an in-order playback mode. Storage is an internal register array with no tri-state bus. It sits between a sample source and a busy-flagged sink, as the next generation of the lab's 16×8 reverse-playback block.

## Interface
- `WIDTH`, 8, data word width in bits (≥1)
- `DEPTH`, 16, buffer entries; power of two, ≥2
- `AW`, `$clog2(DEPTH)`, derived local parameter; not overridable

- `clk`  in  1  single clock; all state changes on rising edge
- `reset`  in  1  asynchronous, active-low reset; clears all state immediately when low
- `i_valid`  in  1  input word valid
- `Din`  in  WIDTH  input word
- `busy`  in  1  downstream cannot accept a word this cycle
- `mode`  in  1  0 = LIFO playback, 1 = FIFO playback; only used with `BURST_REV_FIFO_EN`
- `Dout`  out  WIDTH  output word; all-zero whenever `o_valid`=0
- `o_valid`  out  1  `Dout` carries a valid word this cycle
- `count`  out  AW+1  words currently held, 0..DEPTH
- `full`  out  1  `count`==DEPTH
- `overflow`  out  1  sticky; a word was dropped

## Operation
- Two states: LOAD and DRAIN. Reset state is LOAD.
- Reset values: `o_valid`=0, `Dout`=0, `count`=0, `full`=0, `overflow`=0, write/read pointers 0. Stored contents are discarded.
- LOAD, `i_valid`=1, not full: `Din` is written to `mem[count]` and `count` increments.
  - If `count` was 0, `overflow` clears on the same edge. This marks the start of a new burst.
- LOAD, `i_valid`=1, full: the word is dropped, `overflow` is set, and `count` is unchanged.
- LOAD to DRAIN on an edge where `i_valid`=0, `count`≠0 and `busy`=0.
  - `mode` is latched on this edge.
  - The first word is emitted on the same edge.
- LOAD with `count`=0 and `i_valid`=0: the block idles. `busy` has no effect.
- DRAIN, on each edge:
  - `busy`=0: the next word is registered onto `Dout`, `o_valid`=1, and `count` decrements.
  - `busy`=1: `o_valid`=0, `Dout`=0, and the read pointer holds. No word is lost or duplicated.
- Playback order:
  - LIFO: `mem[N-1]` down to `mem[0]`, where N is `count` at drain start.
  - FIFO: `mem[0]` up to `mem[N-1]`.
- DRAIN to LOAD on the edge that emits the last word (`count` reaches 0). On the following edge `o_valid` returns to 0 unless a new drain starts.
- `i_valid`=1 during DRAIN: the word is dropped and `overflow` is set. Upstream must not send while draining.
- Pointer arithmetic is AW bits and never wraps within a burst, since `count` bounds it. `count` is AW+1 bits so it can represent DEPTH.

## Timing
- Write latency: a word accepted at edge k is reflected in `count` after edge k.
- Drain latency: start condition true in cycle k gives the first `o_valid`=1 in cycle k+1.
- Throughput: one word per cycle in both directions.
- An unstalled drain of N words gives N consecutive `o_valid` cycles.
- `busy` is sampled at the edge. Asserting it in cycle k suppresses output in cycle k+1.
- `full` and `count` are registered and change on the same edge as the write or emit.
- `reset` going low forces all outputs to reset values asynchronously, including mid-drain. Release is synchronised to `clk`.

## Configuration
- `BURST_REV_FIFO_EN` defined: the `mode` input is honoured and latched at drain start.
- Not defined: the `mode` port exists but is ignored. Playback is always LIFO and the FIFO read-pointer logic is not synthesised.

## Test plan
- LIFO basic: write 0x11, 0x22, 0x33, then `i_valid`=0 and `busy`=0 -> `Dout` = 0x33, 0x22, 0x11 on three consecutive `o_valid` cycles; `count` 3→0.
- FIFO mode: same stimulus with `mode`=1 -> 0x11, 0x22, 0x33 with `BURST_REV_FIFO_EN` defined; 0x33, 0x22, 0x11 without it.
- Backpressure: write 0xA0..0xA3, drain, and hold `busy`=1 for 2 cycles after the first output -> 0xA3, gap of 2 cycles with `o_valid`=0 and `Dout`=0, then 0xA2, 0xA1, 0xA0; no loss or duplication.
- Full/overflow: write 0x00..0x10 (17 words, DEPTH=16) -> `full`=1 after 16 writes, 0x10 dropped, `overflow`=1; drain yields 0x0F..0x00; `overflow` clears on the next burst's first write.
- Reset mid-drain: write 5 words, drain 2, pull `reset` low -> `o_valid`=0, `Dout`=0 and `count`=0 without waiting for an edge; after release, a new 2-word burst drains correctly.
- Busy at burst end: write 3 words, then `i_valid`=0 with `busy`=1 for 4 cycles -> no output and `count` stays 3; drain begins the cycle after `busy` falls.
